// File: rtl/dsp_boot_pkg.sv
// dsp_boot_pkg: state encoding, boot-mode constants and default timing shared by the DSP boot sequencer.
package dsp_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_SETUP = 3'd2,
    ST_BOOT0 = 3'd3,
    ST_BOOT1 = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAIL  = 3'd6
  } state_e;

  localparam logic [1:0] BMODE_RSVD       = 2'b00;
  localparam logic [1:0] BMODE_FLASH      = 2'b01;
  localparam logic [1:0] BMODE_SPI_SLAVE  = 2'b10;
  localparam logic [1:0] BMODE_SPI_MASTER = 2'b11;

  localparam int DEF_RST_HOLD_CYC     = 4096;
  localparam int DEF_BMODE_SETUP_CYC  = 64;
  localparam int DEF_BOOT_TIMEOUT_CYC = 16777216;
  localparam int DEF_MAX_RETRY        = 3;
  localparam int DEF_DEBOUNCE_CYC     = 4;

  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    m = (m > d) ? m : d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/dsp_flag_sync.sv
// dsp_flag_sync: 2-FF synchronizer plus consecutive-high debounce for an asynchronous DSP boot-done flag.
module dsp_flag_sync #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_flag,
  output logic o_qual
);
  localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [DW-1:0] DEB = DW'(DEBOUNCE_CYC);

  logic [1:0]    r_sync;
  logic [DW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_flag};
      r_cnt  <= (i_clr || !r_sync[1]) ? '0 : (r_cnt == DEB) ? r_cnt : r_cnt + 1'b1;
    end
  end

  assign o_qual = (r_cnt == DEB);

endmodule

// File: rtl/dsp_boot_sequencer.sv
// dsp_boot_sequencer: holds two DSPs in reset with a stable boot mode, then releases them one at a time
// so they never contend for the shared SPI flash; retries on boot timeout and parks in FAIL when exhausted.
module dsp_boot_sequencer
  import dsp_boot_pkg::*;
#(
  parameter int RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
  parameter int BMODE_SETUP_CYC  = DEF_BMODE_SETUP_CYC,
  parameter int BOOT_TIMEOUT_CYC = DEF_BOOT_TIMEOUT_CYC,
  parameter int MAX_RETRY        = DEF_MAX_RETRY,
  parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [1:0] i_bmode_sel,
  input  logic       i_dsp0_boot_done,
  input  logic       i_dsp1_boot_done,
  output logic       o_dsp0_reset_n,
  output logic       o_dsp1_reset_n,
  output logic [1:0] o_dsp0_bmode,
  output logic [1:0] o_dsp1_bmode,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_fail,
  output logic [2:0] o_state,
  output logic [1:0] o_retry_cnt
);
  localparam int CW = cnt_width(RST_HOLD_CYC, BMODE_SETUP_CYC, BOOT_TIMEOUT_CYC, DEBOUNCE_CYC);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(BMODE_SETUP_CYC - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(BOOT_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [1:0]    RETRY_LIM  = 2'(MAX_RETRY);

  state_e        r_state, w_next;
  logic [CW-1:0] r_cnt, w_last;
  logic [1:0]    r_retry, r_bmode;
  logic          w_q0, w_q1, w_start, w_retry, w_clr, w_rel0, w_rel1, w_busy;

  dsp_flag_sync #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sync0 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_flag  (i_dsp0_boot_done),
    .o_qual  (w_q0)
  );

  dsp_flag_sync #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sync1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_flag  (i_dsp1_boot_done),
    .o_qual  (w_q1)
  );

  // One phase counter serves every timed state; it restarts on each state change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_retry <= '0;
      r_bmode <= BMODE_SPI_MASTER;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
      r_retry <= w_start ? '0 : (w_retry && r_retry != 2'b11) ? r_retry + 1'b1 : r_retry;
      r_bmode <= w_start ? i_bmode_sel : r_bmode;
    end
  end

  // Qualification is tested before the timeout, so a flag landing on the last cycle still advances.
  always_comb begin
    w_last  = (r_state == ST_HOLD) ? HOLD_LAST : (r_state == ST_SETUP) ? SETUP_LAST : TO_LAST;
    w_start = i_start && (r_state inside {ST_IDLE, ST_DONE, ST_FAIL});
    w_next  = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_FAIL:
        w_next = !w_start ? r_state : (i_bmode_sel == BMODE_RSVD) ? ST_FAIL : ST_HOLD;
      ST_HOLD:  w_next = (r_cnt == w_last) ? ST_SETUP : ST_HOLD;
      ST_SETUP: w_next = (r_cnt == w_last) ? ST_BOOT0 : ST_SETUP;
      ST_BOOT0: w_next = w_q0 ? ST_BOOT1 : (r_cnt != w_last) ? ST_BOOT0 :
                         (r_retry < RETRY_LIM) ? ST_HOLD : ST_FAIL;
      ST_BOOT1: w_next = w_q1 ? ST_DONE : (r_cnt != w_last) ? ST_BOOT1 :
                         (r_retry < RETRY_LIM) ? ST_HOLD : ST_FAIL;
      default:  w_next = ST_IDLE;
    endcase
    w_retry = (w_next == ST_HOLD) && (r_state inside {ST_BOOT0, ST_BOOT1});
    w_clr   = (w_next != r_state) && (w_next inside {ST_HOLD, ST_BOOT0, ST_BOOT1});
  end

  always_comb begin
    w_rel0 = r_state inside {ST_BOOT0, ST_BOOT1, ST_DONE};
    w_rel1 = r_state inside {ST_BOOT1, ST_DONE};
    w_busy = r_state inside {ST_HOLD, ST_SETUP, ST_BOOT0, ST_BOOT1};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dsp0_reset_n <= 1'b0;
      o_dsp1_reset_n <= 1'b0;
      o_dsp0_bmode   <= BMODE_SPI_MASTER;
      o_dsp1_bmode   <= BMODE_SPI_MASTER;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_fail         <= 1'b0;
      o_state        <= ST_IDLE;
      o_retry_cnt    <= '0;
    end else begin
      o_dsp0_reset_n <= w_rel0;
      o_dsp1_reset_n <= w_rel1;
      o_dsp0_bmode   <= r_bmode;
      o_dsp1_bmode   <= r_bmode;
      o_busy         <= w_busy;
      o_done         <= (r_state == ST_DONE);
      o_fail         <= (r_state == ST_FAIL);
      o_state        <= r_state;
      o_retry_cnt    <= r_retry;
    end
  end

endmodule

// File: tb/tb_dsp_boot_sequencer.sv
// tb_dsp_boot_sequencer: scenario tasks driving DSP boot-done flags against a phase-level timing model.
module tb_dsp_boot_sequencer;
  localparam int HOLD = 16, SETUP = 4, TO = 100, MAXR = 2, DEB = 4;
  // flag-to-qualify delay: output register, two sync flops, debounce run
  localparam int QLAT = 1 + 2 + DEB;
  localparam logic [2:0] S_IDLE = 3'd0, S_HOLD = 3'd1, S_BOOT1 = 3'd4, S_DONE = 3'd5, S_FAIL = 3'd6;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, f0 = 1'b0, f1 = 1'b0;
  logic [1:0] bsel = 2'b11;
  logic o_r0, o_r1, o_busy, o_done, o_fail;
  logic [1:0] o_bm0, o_bm1, o_retry;
  logic [2:0] o_state;
  int total = 0, bad = 0;
  int p0[3], g0[3], p1[3], g1[3];

  always #5 clk = ~clk;

  dsp_boot_sequencer #(
    .RST_HOLD_CYC(HOLD), .BMODE_SETUP_CYC(SETUP), .BOOT_TIMEOUT_CYC(TO),
    .MAX_RETRY(MAXR), .DEBOUNCE_CYC(DEB)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_bmode_sel(bsel),
    .i_dsp0_boot_done(f0), .i_dsp1_boot_done(f1),
    .o_dsp0_reset_n(o_r0), .o_dsp1_reset_n(o_r1), .o_dsp0_bmode(o_bm0), .o_dsp1_bmode(o_bm1),
    .o_busy(o_busy), .o_done(o_done), .o_fail(o_fail), .o_state(o_state), .o_retry_cnt(o_retry)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit quals(input int p, input int g);
    return p >= 0 && (g == 0 || g >= DEB) && p + QLAT <= TO - 1;
  endfunction

  // Expected outcome of a whole boot from the per-attempt flag plans.
  function automatic void model(output bit d, output int r, output int busy, output int att, output int b0);
    d = 0; r = 0; busy = 0; att = 0; b0 = 0;
    for (int a = 0; a <= MAXR; a++) begin
      att = a + 1;
      r = a;
      busy += HOLD + SETUP;
      if (quals(p0[a], g0[a])) begin
        busy += p0[a] + QLAT + 1;
        b0 += p0[a] + QLAT + 1;
        if (quals(p1[a], g1[a])) begin
          busy += p1[a] + QLAT + 1;
          d = 1;
          break;
        end
        busy += TO;
      end else begin
        busy += TO;
        b0 += TO;
      end
    end
  endfunction

  function automatic void plan(input int a0, input int a1, input int a2, input int b0, input int b1, input int b2);
    p0 = '{a0, a1, a2};
    p1 = '{b0, b1, b2};
    g0 = '{0, 0, 0};
    g1 = '{0, 0, 0};
  endfunction

  task automatic run_boot(input logic [1:0] bm, input bit poke, input string nm);
    int c0, c1, att, ai, busy, rel0, low, bmbad, order, e_r, e_busy, e_att, e_b0;
    bit seen, ok, e_d;
    logic [2:0] ps;
    model(e_d, e_r, e_busy, e_att, e_b0);
    c0 = 0; c1 = 0; att = -1; busy = 0; rel0 = 0; low = 0; bmbad = 0; order = 0;
    seen = 0; ok = 0; ps = o_state;
    bsel = bm;
    start = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      start = poke && cyc == 60;
      bsel = (poke && cyc == 60) ? 2'b00 : bm;
      if (o_state == S_HOLD && ps != S_HOLD) att++;
      ps = o_state;
      if (o_busy) begin
        seen = 1;
        busy++;
        if (!o_r0 && !o_r1) low++;
        if (o_r0 && !o_r1) rel0++;
        if (o_bm0 !== bm || o_bm1 !== bm) bmbad++;
      end
      if (o_r1 && !o_r0) order++;
      ai = (att < 0) ? 0 : (att > 2) ? 2 : att;
      f0 = o_r0 && p0[ai] >= 0 && c0 >= p0[ai] && (g0[ai] == 0 || c0 < p0[ai] + g0[ai]);
      f1 = o_r1 && p1[ai] >= 0 && c1 >= p1[ai] && (g1[ai] == 0 || c1 < p1[ai] + g1[ai]);
      c0 = o_r0 ? c0 + 1 : 0;
      c1 = o_r1 ? c1 + 1 : 0;
      if (seen && !o_busy) begin
        ok = 1;
        break;
      end
    end
    start = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL %s end_of_sequence: busy never settled within bound", nm); end
    total++; if (o_done !== e_d) begin bad++; $display("FAIL %s done: got %b want %b", nm, o_done, e_d); end
    total++; if (o_fail !== !e_d) begin bad++; $display("FAIL %s fail: got %b want %b", nm, o_fail, !e_d); end
    total++; if (o_retry !== 2'(e_r)) begin bad++; $display("FAIL %s retry_cnt: got %0d want %0d", nm, o_retry, e_r); end
    total++; if (busy != e_busy) begin bad++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, busy, e_busy); end
    total++; if (att + 1 != e_att) begin bad++; $display("FAIL %s attempts: got %0d want %0d", nm, att + 1, e_att); end
    total++; if (low != (HOLD + SETUP) * e_att) begin bad++; $display("FAIL %s resets_low_cycles: got %0d want %0d", nm, low, (HOLD + SETUP) * e_att); end
    total++; if (rel0 != e_b0) begin bad++; $display("FAIL %s dsp0_alone_cycles: got %0d want %0d", nm, rel0, e_b0); end
    total++; if (bmbad != 0) begin bad++; $display("FAIL %s bmode_while_busy: got %0d bad cycles want 0", nm, bmbad); end
    total++; if (order != 0) begin bad++; $display("FAIL %s dsp1_before_dsp0: got %0d cycles want 0", nm, order); end
    total++; if ({o_r0, o_r1} !== {e_d, e_d}) begin bad++; $display("FAIL %s final_resets: got %b%b want %b%b", nm, o_r0, o_r1, e_d, e_d); end
  endtask

  task automatic test_reset();
    logic [14:0] want;
    want = {1'b0, 1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, S_IDLE, 2'd0};
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if ({o_r0, o_r1, o_bm0, o_bm1, o_busy, o_done, o_fail, o_state, o_retry} !== want) begin
      bad++; $display("FAIL reset_values: got %h want %h", {o_r0, o_r1, o_bm0, o_bm1, o_busy, o_done, o_fail, o_state, o_retry}, want);
    end
    rst_n = 1'b1;
    repeat (20) tick();
    total++; if ({o_r0, o_r1, o_bm0, o_bm1, o_busy, o_done, o_fail, o_state, o_retry} !== want) begin
      bad++; $display("FAIL idle_hold: got %h want %h", {o_r0, o_r1, o_bm0, o_bm1, o_busy, o_done, o_fail, o_state, o_retry}, want);
    end
  endtask

  task automatic test_nominal();
    plan(30, 30, 30, 30, 30, 30);
    run_boot(2'b11, 0, "nominal");
  endtask

  task automatic test_done_hold();
    f0 = 1'b0;
    f1 = 1'b0;
    repeat (10) tick();
    total++; if ({o_done, o_state, o_r0, o_r1} !== {1'b1, S_DONE, 2'b11}) begin
      bad++; $display("FAIL done_hold: got done=%b state=%0d resets=%b%b want done=1 state=5 resets=11", o_done, o_state, o_r0, o_r1);
    end
  endtask

  task automatic test_back_to_back();
    plan(12, 0, 0, 47, 0, 0);
    run_boot(2'b01, 1, "back_to_back_busy_start");
  endtask

  task automatic test_retry();
    plan(-1, 30, 30, 30, 40, 40);
    run_boot(2'b10, 0, "retry_pass");
  endtask

  task automatic test_exhaust();
    plan(5, 5, 5, -1, -1, -1);
    run_boot(2'b11, 0, "exhaust");
  endtask

  task automatic test_glitch();
    plan(10, 20, 20, 15, 15, 15);
    g0[0] = 3;
    run_boot(2'b01, 0, "glitch");
  endtask

  task automatic test_simultaneous();
    plan(92, 92, 92, 92, 92, 92);
    run_boot(2'b11, 0, "simultaneous_edge");
    plan(93, 92, 92, 0, 92, 92);
    run_boot(2'b10, 0, "one_past_edge");
  endtask

  task automatic test_bmode00();
    bsel = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total++; if ({o_fail, o_busy, o_state} !== {1'b1, 1'b0, S_FAIL}) begin
      bad++; $display("FAIL bmode00: got fail=%b busy=%b state=%0d want fail=1 busy=0 state=6", o_fail, o_busy, o_state);
    end
    plan(8, 8, 8, 8, 8, 8);
    run_boot(2'b11, 0, "restart_from_fail");
  endtask

  task automatic test_reset_mid_boot1();
    bit hit;
    hit = 0;
    bsel = 2'b01;
    start = 1'b1;
    tick();
    start = 1'b0;
    f0 = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (o_state == S_BOOT1) begin
        hit = 1;
        break;
      end
    end
    total++; if (!hit) begin bad++; $display("FAIL reach_boot1: state=%0d want 4 within bound", o_state); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({o_state, o_r0, o_r1, o_bm0, o_bm1, o_busy, o_retry} !== {S_IDLE, 2'b00, 2'b11, 2'b11, 1'b0, 2'd0}) begin
      bad++; $display("FAIL async_reset: got state=%0d resets=%b%b bmode=%b/%b busy=%b want state=0 resets=00 bmode=11/11 busy=0",
                      o_state, o_r0, o_r1, o_bm0, o_bm1, o_busy);
    end
    f0 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [1:0] bm;
    for (int n = 0; n < 6; n++) begin
      for (int a = 0; a < 3; a++) begin
        p0[a] = ($urandom_range(4, 0) == 0) ? -1 : int'($urandom_range(110, 0));
        p1[a] = ($urandom_range(4, 0) == 0) ? -1 : int'($urandom_range(110, 0));
        g0[a] = 0;
        g1[a] = 0;
      end
      bm = 2'($urandom_range(3, 1));
      run_boot(bm, n[0], "random");
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_done_hold();
    test_back_to_back();
    test_retry();
    test_exhaust();
    test_glitch();
    test_simultaneous();
    test_bmode00();
    test_reset_mid_boot1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
